// File: rtl/videogen_pkg.sv
// Shared constants and helpers for the programmable video test-pattern generator:
// pattern codes, colour-bar masks and the timing-config validity check.
package videogen_pkg;

  localparam logic [2:0] PAT_SOLID   = 3'd0;
  localparam logic [2:0] PAT_BARS    = 3'd1;
  localparam logic [2:0] PAT_CHECKER = 3'd2;
  localparam logic [2:0] PAT_RAMP    = 3'd3;
  localparam logic [2:0] PAT_HATCH   = 3'd4;
  localparam logic [2:0] PAT_BORDER  = 3'd5;

  // Widest timing field the validity check accepts; callers zero-extend.
  localparam int CFG_W = 16;

  // Colour-bar order as {R,G,B} masks: white, yellow, cyan, green, magenta, red, blue, black.
  function automatic logic [2:0] bar_mask(input logic [2:0] idx);
    case (idx)
      3'd0:    return 3'b111;
      3'd1:    return 3'b110;
      3'd2:    return 3'b011;
      3'd3:    return 3'b010;
      3'd4:    return 3'b101;
      3'd5:    return 3'b100;
      3'd6:    return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic cfg_valid(
    input logic [CFG_W-1:0] h_total, h_active, h_synclen, h_backporch,
    input logic [CFG_W-1:0] v_total, v_active, v_synclen, v_backporch
  );
    logic [CFG_W+1:0] h_sum;
    logic [CFG_W+1:0] v_sum;
    h_sum = {2'b00, h_synclen} + {2'b00, h_backporch} + {2'b00, h_active};
    v_sum = {2'b00, v_synclen} + {2'b00, v_backporch} + {2'b00, v_active};
    return (h_total != '0) && (h_active != '0) && (v_total != '0) && (v_active != '0) &&
           (h_sum <= {2'b00, h_total}) && (v_sum <= {2'b00, v_total});
  endfunction

endpackage

// File: rtl/vg_pattern.sv
// Combinational pattern map: active-region offset (x, y) plus the frame's
// pattern settings to a packed {R,G,B} pixel.
module vg_pattern #(
  parameter int COLOR_W = 8,
  parameter int H_W     = 12,
  parameter int V_W     = 11
) (
  input  logic [H_W-1:0]       x_i,
  input  logic [V_W-1:0]       y_i,
  input  logic [2:0]           pattern_i,
  input  logic [3*COLOR_W-1:0] bg_rgb_i,
  input  logic [H_W-1:0]       h_active_i,
  input  logic [V_W-1:0]       v_active_i,
  output logic [3*COLOR_W-1:0] rgb_o
);
  import videogen_pkg::*;

  logic [H_W-1:0] bar_w;
  logic [2:0]     bar_idx;
  logic [2:0]     mask;
  logic           x_last;
  logic           y_last;

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and infers a latch.
  always_comb begin
    bar_w   = h_active_i >> 3;
    bar_idx = 3'd0;
    // The last bar keeps every pixel past 7*bar_w, absorbing the remainder.
    for (int i = 1; i < 8; i++) begin
      if ({3'b000, x_i} >= (H_W+3)'(i) * {3'b000, bar_w}) bar_idx = 3'(i);
    end
    mask   = bar_mask(bar_idx);
    x_last = (x_i == h_active_i - H_W'(1));
    y_last = (y_i == v_active_i - V_W'(1));
    rgb_o  = '0;
    case (pattern_i)
      PAT_SOLID:   rgb_o = bg_rgb_i;
      PAT_BARS:    rgb_o = {{COLOR_W{mask[2]}}, {COLOR_W{mask[1]}}, {COLOR_W{mask[0]}}};
      PAT_CHECKER: rgb_o = {(3*COLOR_W){x_i[4] ^ y_i[4]}};
      PAT_RAMP:    rgb_o = {3{x_i[COLOR_W-1:0]}};
      PAT_HATCH:   rgb_o = {(3*COLOR_W){(x_i[3:0] == 4'd0) || (y_i[3:0] == 4'd0) || x_last || y_last}};
      PAT_BORDER:  rgb_o = ((x_i == '0) || (y_i == '0) || x_last || y_last) ? '1 : bg_rgb_i;
      default:     rgb_o = '0;
    endcase
  end

endmodule

// File: rtl/videogen_prog.sv
// Programmable video timing generator: run-time line/frame timing with a
// per-frame shadow config, validity gating and registered RGB/sync/DE outputs.
module videogen_prog #(
  parameter int COLOR_W = 8,
  parameter int H_W     = 12,
  parameter int V_W     = 11
) (
  input  logic                 clk27,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [H_W-1:0]       h_total,
  input  logic [H_W-1:0]       h_active,
  input  logic [H_W-1:0]       h_synclen,
  input  logic [H_W-1:0]       h_backporch,
  input  logic [V_W-1:0]       v_total,
  input  logic [V_W-1:0]       v_active,
  input  logic [V_W-1:0]       v_synclen,
  input  logic [V_W-1:0]       v_backporch,
  input  logic                 hs_pol,
  input  logic                 vs_pol,
  input  logic [2:0]           pattern,
  input  logic [3*COLOR_W-1:0] bg_rgb,
  output logic [COLOR_W-1:0]   R_out,
  output logic [COLOR_W-1:0]   G_out,
  output logic [COLOR_W-1:0]   B_out,
  output logic                 HSYNC_out,
  output logic                 VSYNC_out,
  output logic                 DE_out,
  output logic                 frame_start,
  output logic                 cfg_err
);
  import videogen_pkg::*;

  typedef struct packed {
    logic [H_W-1:0]       h_total, h_active, h_synclen, h_backporch;
    logic [V_W-1:0]       v_total, v_active, v_synclen, v_backporch;
    logic                 hs_pol, vs_pol;
    logic [2:0]           pattern;
    logic [3*COLOR_W-1:0] bg_rgb;
  } cfg_t;

  cfg_t                 live_cfg, cur_cfg, shadow_q, shadow_d;
  logic [H_W-1:0]       h_cnt_q, h_cnt_d, x;
  logic [V_W-1:0]       v_cnt_q, v_cnt_d, y;
  logic                 running_q, running_d, cfg_err_q, cfg_err_d;
  logic                 hs_q, hs_d, vs_q, vs_d, de_q, de_d, fs_q, fs_d;
  logic [3*COLOR_W-1:0] rgb_q, rgb_d, pat_rgb;
  logic                 live_valid, load, run_now, h_wrap, v_wrap;
  logic [H_W:0]         h_start, h_end;
  logic [V_W:0]         v_start, v_end;

  assign live_cfg = '{h_total: h_total, h_active: h_active, h_synclen: h_synclen,
                      h_backporch: h_backporch, v_total: v_total, v_active: v_active,
                      v_synclen: v_synclen, v_backporch: v_backporch, hs_pol: hs_pol,
                      vs_pol: vs_pol, pattern: pattern, bg_rgb: bg_rgb};

  assign live_valid = cfg_valid(CFG_W'(h_total), CFG_W'(h_active), CFG_W'(h_synclen),
                                CFG_W'(h_backporch), CFG_W'(v_total), CFG_W'(v_active),
                                CFG_W'(v_synclen), CFG_W'(v_backporch));

  // When not running, the cycle that starts a frame must already render with the live inputs.
  always_comb begin
    cur_cfg = running_q ? shadow_q : live_cfg;
    h_wrap  = (h_cnt_q == cur_cfg.h_total - H_W'(1));
    v_wrap  = (v_cnt_q == cur_cfg.v_total - V_W'(1));
    load    = enable && (!running_q || (h_wrap && v_wrap));
    run_now = enable && (running_q || live_valid);
    h_start = {1'b0, cur_cfg.h_synclen} + {1'b0, cur_cfg.h_backporch};
    h_end   = h_start + {1'b0, cur_cfg.h_active};
    v_start = {1'b0, cur_cfg.v_synclen} + {1'b0, cur_cfg.v_backporch};
    v_end   = v_start + {1'b0, cur_cfg.v_active};
    x       = h_cnt_q - h_start[H_W-1:0];
    y       = v_cnt_q - v_start[V_W-1:0];
  end

  vg_pattern #(.COLOR_W(COLOR_W), .H_W(H_W), .V_W(V_W)) u_pattern (
    .x_i        (x),
    .y_i        (y),
    .pattern_i  (cur_cfg.pattern),
    .bg_rgb_i   (cur_cfg.bg_rgb),
    .h_active_i (cur_cfg.h_active),
    .v_active_i (cur_cfg.v_active),
    .rgb_o      (pat_rgb)
  );

  always_comb begin
    shadow_d  = load ? live_cfg : shadow_q;
    running_d = running_q;
    cfg_err_d = cfg_err_q;
    h_cnt_d   = '0;
    v_cnt_d   = '0;
    hs_d      = 1'b0;
    vs_d      = 1'b0;
    de_d      = 1'b0;
    fs_d      = 1'b0;
    rgb_d     = '0;
    if (!enable) begin
      running_d = 1'b0;
      cfg_err_d = 1'b0;
    end else if (load) begin
      running_d = live_valid;
      cfg_err_d = !live_valid;
    end
    if (run_now) begin
      h_cnt_d = h_wrap ? '0 : h_cnt_q + H_W'(1);
      v_cnt_d = !h_wrap ? v_cnt_q : (v_wrap ? '0 : v_cnt_q + V_W'(1));
      hs_d    = (h_cnt_q < cur_cfg.h_synclen) ? cur_cfg.hs_pol : ~cur_cfg.hs_pol;
      vs_d    = (v_cnt_q < cur_cfg.v_synclen) ? cur_cfg.vs_pol : ~cur_cfg.vs_pol;
      de_d    = ({1'b0, h_cnt_q} >= h_start) && ({1'b0, h_cnt_q} < h_end) &&
                ({1'b0, v_cnt_q} >= v_start) && ({1'b0, v_cnt_q} < v_end);
      rgb_d   = de_d ? pat_rgb : '0;
      fs_d    = (h_cnt_q == '0) && (v_cnt_q == '0);
    end else if (enable) begin
      hs_d = ~cur_cfg.hs_pol;
      vs_d = ~cur_cfg.vs_pol;
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples the pre-edge values.
  always_ff @(posedge clk27) begin
    if (reset) begin
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      running_q <= 1'b0;
      cfg_err_q <= 1'b0;
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
      de_q      <= 1'b0;
      fs_q      <= 1'b0;
      rgb_q     <= '0;
    end else begin
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      running_q <= running_d;
      cfg_err_q <= cfg_err_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      de_q      <= de_d;
      fs_q      <= fs_d;
      rgb_q     <= rgb_d;
    end
  end

  // NOTE: the shadow config has no reset; it is always loaded from the live inputs before it is used.
  always_ff @(posedge clk27) begin
    shadow_q <= shadow_d;
  end

  assign R_out       = rgb_q[3*COLOR_W-1 -: COLOR_W];
  assign G_out       = rgb_q[2*COLOR_W-1 -: COLOR_W];
  assign B_out       = rgb_q[COLOR_W-1:0];
  assign HSYNC_out   = hs_q;
  assign VSYNC_out   = vs_q;
  assign DE_out      = de_q;
  assign frame_start = fs_q;
  assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_videogen_prog.sv
// Directed bench for videogen_prog: tiny mode, colour bars with a narrow
// 480p-wide frame, shadow timing, invalid config, reset/enable restarts, 10-bit ramp.
module tb_videogen_prog;
  localparam int HW = 12;
  localparam int VW = 11;

  logic clk27 = 1'b0;
  always #5 clk27 = ~clk27;

  logic reset, enable, enable10;
  logic [HW-1:0] h_total, h_active, h_synclen, h_backporch;
  logic [VW-1:0] v_total, v_active, v_synclen, v_backporch;
  logic hs_pol, vs_pol;
  logic [2:0] pattern;
  logic [23:0] bg_rgb;
  logic [7:0] r, g, b;
  logic hs, vs, de, fs, cerr;

  logic [9:0] r10, g10, b10;
  logic hs10, vs10, de10, fs10, cerr10;

  int checks = 0;
  int failures = 0;
  int k = 0;
  int hs_low, vs_low, de_cnt, rgb_bad, fs_cnt, first_de;
  int bar_x [8] = '{0, 89, 90, 180, 270, 360, 450, 540};
  logic [23:0] bar_c [8] = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFF00, 24'h00FFFF,
                             24'h00FF00, 24'hFF00FF, 24'hFF0000, 24'h0000FF};

  videogen_prog dut (
    .clk27(clk27), .reset(reset), .enable(enable),
    .h_total(h_total), .h_active(h_active), .h_synclen(h_synclen), .h_backporch(h_backporch),
    .v_total(v_total), .v_active(v_active), .v_synclen(v_synclen), .v_backporch(v_backporch),
    .hs_pol(hs_pol), .vs_pol(vs_pol), .pattern(pattern), .bg_rgb(bg_rgb),
    .R_out(r), .G_out(g), .B_out(b), .HSYNC_out(hs), .VSYNC_out(vs), .DE_out(de),
    .frame_start(fs), .cfg_err(cerr)
  );

  videogen_prog #(.COLOR_W(10)) dut10 (
    .clk27(clk27), .reset(reset), .enable(enable10),
    .h_total(12'd1100), .h_active(12'd1024), .h_synclen(12'd8), .h_backporch(12'd8),
    .v_total(11'd3), .v_active(11'd1), .v_synclen(11'd1), .v_backporch(11'd0),
    .hs_pol(1'b1), .vs_pol(1'b1), .pattern(3'd3), .bg_rgb(30'd0),
    .R_out(r10), .G_out(g10), .B_out(b10), .HSYNC_out(hs10), .VSYNC_out(vs10), .DE_out(de10),
    .frame_start(fs10), .cfg_err(cerr10)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) @(negedge clk27);
    k += n;
  endtask

  task automatic goto_k(input int t);
    adv(t - k);
  endtask

  task automatic set_cfg(input int ht, ha, hsl, hbp, vt, va, vsl, vbp);
    h_total = HW'(ht); h_active = HW'(ha); h_synclen = HW'(hsl); h_backporch = HW'(hbp);
    v_total = VW'(vt); v_active = VW'(va); v_synclen = VW'(vsl); v_backporch = VW'(vbp);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; enable10 = 1'b0;
    set_cfg(10, 4, 2, 2, 6, 3, 1, 1);
    hs_pol = 1'b0; vs_pol = 1'b0; pattern = 3'd0; bg_rgb = 24'h123456;
    repeat (3) @(negedge clk27);
    check("reset_ctl", 32'({hs, vs, de, fs, cerr}), 32'd0);
    check("reset_rgb", 32'({r, g, b}), 32'd0);

    // Tiny mode: one full 60-cycle frame starting one cycle after reset release.
    reset = 1'b0;
    adv(1); k = 0;
    check("tiny_fs_first", 32'(fs), 32'd1);
    hs_low = 0; vs_low = 0; de_cnt = 0; rgb_bad = 0; fs_cnt = 0; first_de = -1;
    for (int i = 0; i < 60; i++) begin
      if (!hs) hs_low++;
      if (!vs) vs_low++;
      if (fs) fs_cnt++;
      if (de) begin
        de_cnt++;
        if (first_de < 0) first_de = i;
        if ({r, g, b} !== 24'h123456) rgb_bad++;
      end else if ({r, g, b} !== 24'h0) rgb_bad++;
      adv(1);
    end
    check("tiny_hs_low", 32'(hs_low), 32'd12);
    check("tiny_vs_low", 32'(vs_low), 32'd10);
    check("tiny_de_cnt", 32'(de_cnt), 32'd12);
    check("tiny_first_de", 32'(first_de), 32'd24);
    check("tiny_rgb_bad", 32'(rgb_bad), 32'd0);
    check("tiny_fs_cnt", 32'(fs_cnt), 32'd1);
    check("tiny_fs_period", 32'(fs), 32'd1);

    enable = 1'b0;
    adv(3);
    check("en_low_hs", 32'(hs), 32'd0);
    check("en_low_fs", 32'(fs), 32'd0);

    // 480p-wide lines with a 4-line frame: bars, vsync, frame period.
    set_cfg(858, 720, 62, 60, 4, 2, 1, 0);
    hs_pol = 1'b1; vs_pol = 1'b1; pattern = 3'd1;
    enable = 1'b1;
    adv(1); k = 0;
    check("bars_fs_first", 32'(fs), 32'd1);
    check("bars_vs_l0", 32'(vs), 32'd1);
    goto_k(857);
    check("bars_vs_l0_end", 32'(vs), 32'd1);
    goto_k(858);
    check("bars_vs_l1", 32'(vs), 32'd0);
    goto_k(979);
    check("bars_de_pre", 32'(de), 32'd0);
    for (int i = 0; i < 8; i++) begin
      goto_k(980 + bar_x[i]);
      check($sformatf("bar_x%0d", bar_x[i]), 32'({r, g, b}), 32'(bar_c[i]));
    end
    goto_k(980 + 630);
    check("bar_black_de", 32'(de), 32'd1);
    check("bar_black_rgb", 32'({r, g, b}), 32'd0);
    goto_k(980 + 720);
    check("bars_de_post", 32'(de), 32'd0);

    // Pattern change mid-frame holds until the next frame.
    pattern = 3'd2;
    goto_k(1933);
    check("shadow_hold", 32'({r, g, b}), 32'hFFFF00);
    goto_k(3431);
    check("fs_not_early", 32'(fs), 32'd0);
    goto_k(3432);
    check("fs_period", 32'(fs), 32'd1);
    goto_k(4427);
    check("chk_x15_de", 32'(de), 32'd1);
    check("chk_x15", 32'({r, g, b}), 32'd0);
    goto_k(4428);
    check("chk_x16", 32'({r, g, b}), 32'hFFFFFF);
    goto_k(4443);
    check("chk_x31", 32'({r, g, b}), 32'hFFFFFF);
    goto_k(4444);
    check("chk_x32", 32'({r, g, b}), 32'd0);

    // Invalid horizontal config applied at the frame boundary, then restored.
    goto_k(4500);
    h_active = 12'd800;
    goto_k(6864);
    check("inv_no_fs", 32'(fs), 32'd0);
    goto_k(6870);
    check("inv_cfg_err", 32'(cerr), 32'd1);
    check("inv_de", 32'(de), 32'd0);
    check("inv_syncs", 32'({hs, vs}), 32'd0);
    goto_k(6880);
    h_active = 12'd720;
    adv(1);
    check("restore_fs", 32'(fs), 32'd1);
    check("restore_err", 32'(cerr), 32'd0);
    check("restore_hs", 32'(hs), 32'd1);
    k = 0;

    // Reset mid-line on an active pixel.
    goto_k(1158);
    check("pre_rst_de", 32'(de), 32'd1);
    check("pre_rst_rgb", 32'({r, g, b}), 32'hFFFFFF);
    reset = 1'b1;
    adv(1);
    check("rst_de", 32'(de), 32'd0);
    check("rst_rgb", 32'({r, g, b}), 32'd0);
    adv(2);
    reset = 1'b0;
    adv(1); k = 0;
    check("rst_restart_fs", 32'(fs), 32'd1);

    // Five-cycle enable low pulse.
    goto_k(1158);
    check("pre_en_de", 32'(de), 32'd1);
    enable = 1'b0;
    adv(1);
    check("en_pulse_de", 32'(de), 32'd0);
    check("en_pulse_rgb", 32'({r, g, b}), 32'd0);
    adv(4);
    enable = 1'b1;
    adv(1);
    check("en_resume_fs", 32'(fs), 32'd1);
    check("en_resume_syncs", 32'({hs, vs}), 32'd3);

    // 10-bit grey ramp across 1024 active pixels.
    enable10 = 1'b1;
    adv(1); k = 0;
    check("ramp_fs", 32'(fs10), 32'd1);
    goto_k(1116);
    check("ramp_x0_de", 32'(de10), 32'd1);
    check("ramp_x0", 32'({r10, g10, b10}), 32'd0);
    goto_k(1121);
    check("ramp_x5", 32'({r10, g10, b10}), 32'({3{10'd5}}));
    goto_k(2139);
    check("ramp_x1023", 32'({r10, g10, b10}), 32'({3{10'd1023}}));
    adv(1);
    check("ramp_de_end", 32'(de10), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
